snake_game_ctrl: RTL

Game sequencer for the snake playfield. It derives a game tick from the VGA vsync, latches player direction input and steps the head position on each tick. It also detects food and wall collisions, relocates food with an internal LFSR and speeds the game up as the score rises. It sits between the button inputs and the renderer; its head_x/head_y/food_x/food_y outputs replace the renderer's fixed food registers.

---
 rtl/snake_pkg.sv | 37 +++
 rtl/snake_game_ctrl_frame_tick.sv | 43 ++++
 rtl/snake_game_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game sequencer.
package snake_pkg;

    localparam int unsigned GRID_W = 80;
    localparam int unsigned GRID_H = 60;

    localparam logic [6:0] START_X = 7'd40;
    localparam logic [5:0] START_Y = 6'd30;
    localparam logic [6:0] FOOD0_X = 7'd20;
    localparam logic [5:0] FOOD0_Y = 6'd30;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        MOVE  = 3'd2,
        CHECK = 3'd3,
        PLACE = 3'd4,
        OVER  = 3'd5
    } state_t;

    function automatic dir_t reverse_of(input dir_t d);
        case (d)
            UP:      reverse_of = DOWN;
            DOWN:    reverse_of = UP;
            LEFT:    reverse_of = RIGHT;
            default: reverse_of = LEFT;
        endcase
    endfunction

endpackage

// File: rtl/snake_game_ctrl_frame_tick.sv
// Synchronises vsync, detects frame starts and divides frames into game ticks.
module snake_frame_tick (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic [6:0] game_speed,
    input  logic       clear,
    output logic       tick
);

    logic [1:0] vsync_sync;
    logic       vsync_d;
    logic       frame_pulse;
    logic [6:0] count;
    logic       at_limit;

    assign frame_pulse = vsync_sync[1] & ~vsync_d;
    assign at_limit    = ({1'b0, count} + 8'd1) >= {1'b0, game_speed};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_sync <= '0;
            vsync_d    <= 1'b0;
            count      <= '0;
            tick       <= 1'b0;
        end else begin
            vsync_sync <= {vsync_sync[0], vsync};
            vsync_d    <= vsync_sync[1];
            tick       <= 1'b0;
            if (clear) begin
                count <= '0;
            end else if (frame_pulse) begin
                if (at_limit) begin
                    count <= '0;
                    tick  <= 1'b1;
                end else begin
                    count <= count + 7'd1;
                end
            end
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: frame-derived tick, direction latch, head stepping,
// food/wall collision, LFSR food placement and score-driven speed-up.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned START_SPEED = 60,
    parameter int unsigned MIN_SPEED   = 8,
    parameter int unsigned SPEED_STEP  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [6:0] head_x,
    output logic [5:0] head_y,
    output logic [6:0] food_x,
    output logic [5:0] food_y,
    output logic [6:0] game_speed,
    output logic [7:0] score,
    output logic       tick,
    output logic       grow,
    output logic       game_over,
    output logic       playing
);

    localparam logic [6:0] X_MAX       = 7'(GRID_W - 1);
    localparam logic [5:0] Y_MAX       = 6'(GRID_H - 1);
    localparam logic [6:0] X_LIM       = 7'(GRID_W);
    localparam logic [5:0] Y_LIM       = 6'(GRID_H);
    localparam logic [6:0] SPEED_INIT  = 7'(START_SPEED);
    localparam logic [6:0] SPEED_MIN   = 7'(MIN_SPEED);
    localparam logic [6:0] SPEED_DEC   = 7'(SPEED_STEP);
    localparam logic [7:0] SPEED_FLOOR = 8'(MIN_SPEED + SPEED_STEP);

    state_t      state, state_next;
    dir_t        dir, pending_dir, sel_dir;
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic        btn_any, btn_any_d, btn_edge;
    logic [6:0]  next_x, cand_x, speed_lowered;
    logic [5:0]  next_y, cand_y;
    logic        blocked, hit, cand_ok, speed_clear;

    assign btn_any     = btn_up | btn_down | btn_left | btn_right;
    assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign hit         = (head_x == food_x) && (head_y == food_y);
    assign cand_x      = lfsr[6:0];
    assign cand_y      = lfsr[13:8];
    assign cand_ok     = (cand_x < X_LIM) && (cand_y < Y_LIM) &&
                         !((cand_x == head_x) && (cand_y == head_y));
    // Clamp before subtracting so a small speed never wraps around.
    assign speed_lowered = ({1'b0, game_speed} >= SPEED_FLOOR) ?
                           (game_speed - SPEED_DEC) : SPEED_MIN;
    assign speed_clear = ((state == IDLE) && btn_edge) || ((state == CHECK) && hit);

    snake_frame_tick u_frame_tick (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .game_speed (game_speed),
        .clear      (speed_clear),
        .tick       (tick)
    );

    always_comb begin
        if (btn_up)        sel_dir = UP;
        else if (btn_down) sel_dir = DOWN;
        else if (btn_left) sel_dir = LEFT;
        else               sel_dir = RIGHT;
    end

    always_comb begin
        next_x  = head_x;
        next_y  = head_y;
        blocked = 1'b0;
        case (pending_dir)
            UP:      if (head_y == '0)    blocked = 1'b1; else next_y = head_y - 6'd1;
            DOWN:    if (head_y == Y_MAX) blocked = 1'b1; else next_y = head_y + 6'd1;
            LEFT:    if (head_x == '0)    blocked = 1'b1; else next_x = head_x - 7'd1;
            default: if (head_x == X_MAX) blocked = 1'b1; else next_x = head_x + 7'd1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (btn_edge) state_next = RUN;
            RUN:     if (tick)     state_next = MOVE;
            MOVE:    state_next = blocked ? OVER : CHECK;
            CHECK:   state_next = hit ? PLACE : RUN;
            PLACE:   if (cand_ok)  state_next = RUN;
            OVER:    if (btn_edge) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        game_over = (state == OVER);
        playing   = (state == RUN) || (state == MOVE) || (state == CHECK) || (state == PLACE);
        grow      = (state == CHECK) && hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_x      <= START_X;
            head_y      <= START_Y;
            food_x      <= FOOD0_X;
            food_y      <= FOOD0_Y;
            game_speed  <= SPEED_INIT;
            score       <= '0;
            dir         <= LEFT;
            pending_dir <= LEFT;
            lfsr        <= 16'hACE1;
            btn_any_d   <= 1'b0;
            btn_edge    <= 1'b0;
        end else begin
            lfsr      <= {lfsr[14:0], lfsr_fb};
            btn_any_d <= btn_any;
            btn_edge  <= btn_any & ~btn_any_d;
            case (state)
                IDLE: begin
                    if (btn_edge) begin
                        score       <= '0;
                        game_speed  <= SPEED_INIT;
                        head_x      <= START_X;
                        head_y      <= START_Y;
                        dir         <= LEFT;
                        pending_dir <= LEFT;
                    end
                end
                RUN: begin
                    if (btn_any && (sel_dir != reverse_of(dir))) pending_dir <= sel_dir;
                end
                MOVE: begin
                    dir <= pending_dir;
                    if (!blocked) begin
                        head_x <= next_x;
                        head_y <= next_y;
                    end
                end
                CHECK: begin
                    if (hit) begin
                        if (score != 8'hFF) score <= score + 8'd1;
                        game_speed <= speed_lowered;
                    end
                end
                PLACE: begin
                    if (cand_ok) begin
                        food_x <= cand_x;
                        food_y <= cand_y;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
